// File: rtl/amci_axi4lite_master_pkg.sv
// Shared AMCI bus layout: field offsets and widths of the 98-bit MOSI and 38-bit MISO buses.
// Every AMCI master and controller imports these so that the packing stays in one place.
package amci_axi4lite_master_pkg;

  localparam int AMCI_WORD_W    = 32;
  localparam int AMCI_RESP_W    = 2;

  localparam int AMCI_MOSI_W    = 98;
  localparam int AMCI_WADDR_LSB = 0;
  localparam int AMCI_WDATA_LSB = 32;
  localparam int AMCI_RADDR_LSB = 64;
  localparam int AMCI_WRITE_BIT = 96;
  localparam int AMCI_READ_BIT  = 97;

  localparam int AMCI_MISO_W    = 38;
  localparam int AMCI_RDATA_LSB = 0;
  localparam int AMCI_WIDLE_BIT = 32;
  localparam int AMCI_RIDLE_BIT = 33;
  localparam int AMCI_WRESP_LSB = 34;
  localparam int AMCI_RRESP_LSB = 36;

endpackage

// File: rtl/amci_axi4lite_master.sv
// Bus end of the AMCI link: turns AMCI write/read strobes into AXI4-Lite master transactions
// using two independent engines, and reports idle flags, responses and read data on AMCI_MISO.
module amci_axi4lite_master
  import amci_axi4lite_master_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                          CLK,
  input  logic                          RESETN,
  input  logic [AMCI_MOSI_W-1:0]        AMCI_MOSI,
  output logic [AMCI_MISO_W-1:0]        AMCI_MISO,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam logic [1:0] W_IDLE      = 2'd0;
  localparam logic [1:0] W_ADDR_DATA = 2'd1;
  localparam logic [1:0] W_RESP      = 2'd2;

  localparam logic [1:0] R_IDLE      = 2'd0;
  localparam logic [1:0] R_ADDR      = 2'd1;
  localparam logic [1:0] R_DATA      = 2'd2;

  logic [1:0]                  w_state;
  logic [1:0]                  r_state;
  logic [AMCI_RESP_W-1:0]      wresp;
  logic [AMCI_RESP_W-1:0]      rresp;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic                        write_req;
  logic                        read_req;
  logic                        w_idle;
  logic                        r_idle;
  logic                        aw_done;
  logic                        w_done;

  assign write_req = AMCI_MOSI[AMCI_WRITE_BIT];
  assign read_req  = AMCI_MOSI[AMCI_READ_BIT];

  // A strobe already pulls its idle flag low, so a poll right after raising it never sees a stale 1.
  assign w_idle = (w_state == W_IDLE) && !write_req;
  assign r_idle = (r_state == R_IDLE) && !read_req;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;

  // A channel counts as done once its valid has dropped or its handshake lands on this edge.
  assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_done  = !M_AXI_WVALID  || M_AXI_WREADY;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      w_state       <= W_IDLE;
      M_AXI_AWADDR  <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      wresp         <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (write_req) begin
            M_AXI_AWADDR  <= AMCI_MOSI[AMCI_WADDR_LSB +: AMCI_WORD_W];
            M_AXI_WDATA   <= AMCI_MOSI[AMCI_WDATA_LSB +: AMCI_WORD_W];
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            w_state       <= W_ADDR_DATA;
          end
        end
        W_ADDR_DATA: begin
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          if (aw_done && w_done) begin
            M_AXI_BREADY <= 1'b1;
            w_state      <= W_RESP;
          end
        end
        W_RESP: begin
          if (M_AXI_BVALID) begin
            wresp        <= M_AXI_BRESP;
            M_AXI_BREADY <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state       <= R_IDLE;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rdata         <= '0;
      rresp         <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (read_req) begin
            M_AXI_ARADDR  <= AMCI_MOSI[AMCI_RADDR_LSB +: AMCI_WORD_W];
            M_AXI_ARVALID <= 1'b1;
            r_state       <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (M_AXI_RVALID) begin
            rdata        <= M_AXI_RDATA;
            rresp        <= M_AXI_RRESP;
            M_AXI_RREADY <= 1'b0;
            r_state      <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    AMCI_MISO = '0;
    AMCI_MISO[AMCI_RDATA_LSB +: AMCI_WORD_W] = rdata;
    AMCI_MISO[AMCI_WIDLE_BIT]                = w_idle;
    AMCI_MISO[AMCI_RIDLE_BIT]                = r_idle;
    AMCI_MISO[AMCI_WRESP_LSB +: AMCI_RESP_W] = wresp;
    AMCI_MISO[AMCI_RRESP_LSB +: AMCI_RESP_W] = rresp;
  end

endmodule
